regfile_ctrl: RTL and testbench

- Sequencing controller for the scoreboarded register file built from NREG register cells, each with a write-reserve bit.
- Issue side: reserves destination registers and stalls issue on RAW/WAW hazards, judged from the cells' reserved bits.
- Writeback side: round-robin arbitration of N_FU functional-unit results onto the single register-file write port, through one registered writeback stage.
- Sits between the issue stage, the FUs and the register-cell array.

---
 rtl/regfile_ctrl_pkg.sv | 18 +
 rtl/regfile_ctrl_rr_arbiter.sv | 30 +++
 rtl/regfile_ctrl.sv | 107 ++++++++++
 tb/tb_regfile_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants for the scoreboarded register-file controller.
package regfile_ctrl_pkg;

   localparam int unsigned WORD = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned RIDX = 5;
   localparam int unsigned N_FU = 3;

   localparam int unsigned FU_ALU = 0;
   localparam int unsigned FU_MUL = 1;
   localparam int unsigned FU_LSU = 2;

   // Width of a pointer that can address n requesters (at least one bit).
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// scanning upward with wrap. The pointer itself is owned by the caller.
module rr_arbiter
   import regfile_ctrl_pkg::*;
#(
   parameter int unsigned N  = 3,
   parameter int unsigned PW = ptr_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   int unsigned idx;
   logic        found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = (i + 32'(ptr)) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_ctrl.sv
// Issue-side hazard check / reservation and writeback arbitration for the
// scoreboarded register file; one registered writeback stage.
module regfile_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter int unsigned WORD = regfile_ctrl_pkg::WORD,
   parameter int unsigned NREG = regfile_ctrl_pkg::NREG,
   parameter int unsigned RIDX = regfile_ctrl_pkg::RIDX,
   parameter int unsigned N_FU = regfile_ctrl_pkg::N_FU
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iss_valid_i,
   input  logic [RIDX-1:0]      iss_rd_i,
   input  logic [RIDX-1:0]      iss_rs1_i,
   input  logic [RIDX-1:0]      iss_rs2_i,
   input  logic                 iss_use_rs1_i,
   input  logic                 iss_use_rs2_i,
   output logic                 iss_ready_o,
   input  logic [NREG-1:0]      w_reserved_i,
   output logic [NREG-1:0]      w_reserve_o,
   output logic [NREG-1:0]      wb_o,
   output logic [WORD-1:0]      wb_data_o,
   input  logic [N_FU-1:0]      fu_valid_i,
   input  logic [N_FU*RIDX-1:0] fu_rd_i,
   input  logic [N_FU*WORD-1:0] fu_data_i,
   output logic [N_FU-1:0]      fu_ready_o,
   output logic                 err_o
);

   localparam int unsigned PW = ptr_width(N_FU);

   logic            raw;
   logic            waw;
   logic [N_FU-1:0] req;
   logic [N_FU-1:0] grant;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   ptr_next;
   logic [RIDX-1:0] sel_rd;
   logic [WORD-1:0] sel_data;
   logic            granted;

   // ---------------- issue side ----------------
   always_comb begin
      raw = (iss_use_rs1_i && iss_rs1_i != '0 && w_reserved_i[iss_rs1_i]) ||
            (iss_use_rs2_i && iss_rs2_i != '0 && w_reserved_i[iss_rs2_i]);
      waw = (iss_rd_i != '0) && w_reserved_i[iss_rd_i];
      iss_ready_o = !raw && !waw;
   end

   always_comb begin
      w_reserve_o = '0;
      if (rst && iss_valid_i && iss_ready_o && iss_rd_i != '0)
         w_reserve_o[iss_rd_i] = 1'b1;
   end

   // ---------------- writeback arbitration ----------------
   // Gating requests with rst keeps the grant (and thus any state update) quiet in reset.
   assign req = fu_valid_i & {N_FU{rst}};

   rr_arbiter #(
      .N  (N_FU),
      .PW (PW)
   ) u_arb (
      .req   (req),
      .ptr   (ptr),
      .grant (grant)
   );

   assign fu_ready_o = grant;
   assign granted    = |grant;

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      ptr_next = ptr;
      for (int unsigned k = 0; k < N_FU; k++) begin
         if (grant[k]) begin
            sel_rd   = fu_rd_i[k*RIDX +: RIDX];
            sel_data = fu_data_i[k*WORD +: WORD];
            ptr_next = PW'((k + 1) % N_FU);
         end
      end
   end

   // ---------------- writeback stage ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr       <= '0;
         wb_o      <= '0;
         wb_data_o <= '0;
         err_o     <= 1'b0;
      end else begin
         ptr  <= ptr_next;
         wb_o <= '0;
         if (granted) begin
            wb_data_o <= sel_data;
            if (sel_rd != '0) begin
               wb_o[sel_rd] <= 1'b1;
               if (!w_reserved_i[sel_rd])
                  err_o <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl; writeback expectations flow through a
// scoreboard queue filled when FU results are presented.
module tb_regfile_ctrl;
   import regfile_ctrl_pkg::*;

   logic                 clk;
   logic                 rst;
   logic                 iss_valid_i;
   logic [RIDX-1:0]      iss_rd_i;
   logic [RIDX-1:0]      iss_rs1_i;
   logic [RIDX-1:0]      iss_rs2_i;
   logic                 iss_use_rs1_i;
   logic                 iss_use_rs2_i;
   logic                 iss_ready_o;
   logic [NREG-1:0]      w_reserved_i;
   logic [NREG-1:0]      w_reserve_o;
   logic [NREG-1:0]      wb_o;
   logic [WORD-1:0]      wb_data_o;
   logic [N_FU-1:0]      fu_valid_i;
   logic [N_FU*RIDX-1:0] fu_rd_i;
   logic [N_FU*WORD-1:0] fu_data_i;
   logic [N_FU-1:0]      fu_ready_o;
   logic                 err_o;

   regfile_ctrl #(
      .WORD (WORD),
      .NREG (NREG),
      .RIDX (RIDX),
      .N_FU (N_FU)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .iss_valid_i   (iss_valid_i),
      .iss_rd_i      (iss_rd_i),
      .iss_rs1_i     (iss_rs1_i),
      .iss_rs2_i     (iss_rs2_i),
      .iss_use_rs1_i (iss_use_rs1_i),
      .iss_use_rs2_i (iss_use_rs2_i),
      .iss_ready_o   (iss_ready_o),
      .w_reserved_i  (w_reserved_i),
      .w_reserve_o   (w_reserve_o),
      .wb_o          (wb_o),
      .wb_data_o     (wb_data_o),
      .fu_valid_i    (fu_valid_i),
      .fu_rd_i       (fu_rd_i),
      .fu_data_i     (fu_data_i),
      .fu_ready_o    (fu_ready_o),
      .err_o         (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NREG-1:0] wb;
      logic [WORD-1:0] data;
      bit              has_data;
   } exp_t;

   exp_t        q[$];
   int unsigned passed = 0;
   int unsigned total  = 0;
   int unsigned m_ptr  = 0;
   bit          m_err  = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [NREG-1:0] bit_at(input int unsigned r);
      logic [NREG-1:0] v;
      v = '0;
      v[r] = 1'b1;
      return v;
   endfunction

   // Evaluate the presented FU results against a reference round-robin order
   // and queue what the writeback stage must show next cycle.
   task automatic fu_eval();
      logic [N_FU-1:0] g;
      int unsigned     k;
      logic [RIDX-1:0] rd;
      exp_t            e;
      #1;
      g = '0;
      k = 0;
      if (fu_valid_i[m_ptr])                    k = m_ptr;
      else if (fu_valid_i[(m_ptr + 1) % N_FU])  k = (m_ptr + 1) % N_FU;
      else                                      k = (m_ptr + 2) % N_FU;
      if (fu_valid_i != '0) g[k] = 1'b1;
      chk("fu_ready", 64'(fu_ready_o), 64'(g));
      if (g != '0) begin
         rd         = fu_rd_i[k*RIDX +: RIDX];
         e.wb       = (rd != 0) ? bit_at(rd) : '0;
         e.data     = fu_data_i[k*WORD +: WORD];
         e.has_data = (rd != 0);
         q.push_back(e);
         if (rd != 0 && !w_reserved_i[rd]) m_err = 1'b1;
         m_ptr = (k + 1) % N_FU;
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("wb_o", 64'(wb_o), 64'(e.wb));
         if (e.has_data) chk("wb_data", 64'(wb_data_o), 64'(e.data));
      end else begin
         chk("wb_idle", 64'(wb_o), 64'd0);
      end
      chk("err", 64'(err_o), 64'(m_err));
      @(negedge clk);
   endtask

   task automatic cycle();
      fu_eval();
      tick();
   endtask

   task automatic set_fu(input int unsigned k, input logic [RIDX-1:0] rd, input logic [WORD-1:0] d);
      fu_rd_i[k*RIDX +: RIDX]   = rd;
      fu_data_i[k*WORD +: WORD] = d;
   endtask

   initial begin
      rst           = 1'b0;
      iss_valid_i   = 1'b1;
      iss_rd_i      = 5;
      iss_rs1_i     = 1;
      iss_rs2_i     = 2;
      iss_use_rs1_i = 1'b1;
      iss_use_rs2_i = 1'b1;
      w_reserved_i  = '0;
      fu_valid_i    = '1;
      fu_rd_i       = '0;
      fu_data_i     = '0;
      set_fu(FU_ALU, 3, 32'h1);
      set_fu(FU_MUL, 4, 32'h2);
      set_fu(FU_LSU, 6, 32'h3);

      // reset state, with requests present
      #1;
      chk("rst_wb", 64'(wb_o), 64'd0);
      chk("rst_wbdata", 64'(wb_data_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_fu_ready", 64'(fu_ready_o), 64'd0);
      chk("rst_reserve", 64'(w_reserve_o), 64'd0);
      @(negedge clk);
      rst        = 1'b1;
      fu_valid_i = '0;

      // accept with no hazards; reserve strobe same cycle
      #1;
      chk("iss_ready_free", 64'(iss_ready_o), 64'd1);
      chk("reserve_rd5", 64'(w_reserve_o), 64'(bit_at(5)));
      cycle();

      // RAW on rs1=5
      w_reserved_i[5] = 1'b1;
      iss_rs1_i = 5;
      iss_rd_i  = 6;
      #1;
      chk("raw_stall", 64'(iss_ready_o), 64'd0);
      chk("raw_no_reserve", 64'(w_reserve_o), 64'd0);
      iss_valid_i = 1'b0;
      cycle();

      // ALU writes reg 5; dependent issue stalls through the wb_o cycle
      fu_valid_i = 3'b001;
      set_fu(FU_ALU, 5, 32'hDEADBEEF);
      cycle();
      fu_valid_i  = '0;
      iss_valid_i = 1'b1;
      #1;
      chk("dep_stall_wb", 64'(iss_ready_o), 64'd0);
      cycle();
      w_reserved_i[5] = 1'b0;
      #1;
      chk("dep_accept", 64'(iss_ready_o), 64'd1);
      chk("dep_reserve", 64'(w_reserve_o), 64'(bit_at(6)));
      iss_valid_i = 1'b0;
      cycle();

      // LSU result to rd=0: consumed, no strobe; pointer wraps to ALU
      fu_valid_i = 3'b100;
      set_fu(FU_LSU, 0, 32'h5555AAAA);
      cycle();

      // all three FUs valid: 001, 010, 100, 001
      w_reserved_i[3] = 1'b1;
      w_reserved_i[4] = 1'b1;
      w_reserved_i[6] = 1'b1;
      set_fu(FU_ALU, 3, 32'h11110003);
      set_fu(FU_MUL, 4, 32'h22220004);
      set_fu(FU_LSU, 6, 32'h33330006);
      fu_valid_i = 3'b111;
      for (int i = 0; i < 4; i++) cycle();
      fu_valid_i = '0;
      cycle();
      w_reserved_i = '0;

      // WAW on rd=7, then rd=0 with nothing reserved
      w_reserved_i[7] = 1'b1;
      iss_valid_i   = 1'b1;
      iss_rd_i      = 7;
      iss_use_rs1_i = 1'b0;
      iss_use_rs2_i = 1'b0;
      #1;
      chk("waw_stall", 64'(iss_ready_o), 64'd0);
      chk("waw_no_reserve", 64'(w_reserve_o), 64'd0);
      cycle();
      w_reserved_i = '0;
      iss_rd_i     = 0;
      #1;
      chk("rd0_accept", 64'(iss_ready_o), 64'd1);
      chk("rd0_no_reserve", 64'(w_reserve_o), 64'd0);
      iss_valid_i = 1'b0;
      cycle();

      // MUL result to unreserved reg 9: error, write still happens, sticky
      fu_valid_i = 3'b010;
      set_fu(FU_MUL, 9, 32'hCAFEF00D);
      cycle();
      fu_valid_i = '0;
      cycle();
      cycle();

      // reset while a grant is pending: nothing written, pointer and err cleared
      w_reserved_i[3] = 1'b1;
      w_reserved_i[4] = 1'b1;
      set_fu(FU_ALU, 3, 32'hA0A0A0A0);
      set_fu(FU_MUL, 4, 32'hB0B0B0B0);
      set_fu(FU_LSU, 4, 32'hC0C0C0C0);
      fu_valid_i = 3'b011;
      fu_eval();
      q.delete();
      rst = 1'b0;
      #1;
      chk("mid_rst_fu_ready", 64'(fu_ready_o), 64'd0);
      @(posedge clk);
      #1;
      chk("mid_rst_wb", 64'(wb_o), 64'd0);
      chk("mid_rst_err", 64'(err_o), 64'd0);
      m_ptr = 0;
      m_err = 1'b0;
      @(negedge clk);
      rst        = 1'b1;
      fu_valid_i = 3'b110;
      cycle();
      fu_valid_i = '0;
      cycle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
